// File: rtl/nbit_sync_down_timer_pkg.sv
// rtl/nbit_sync_down_timer_pkg.sv - shared types and defaults for the down timer
package nbit_sync_down_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nbit_sync_down_timer_down_cnt_core.sv
// rtl/nbit_sync_down_timer_down_cnt_core.sv - count register with clear/load/reload/decrement
// Control priority is clr > load > reload > dec; a zero count is never decremented.
module nbit_sync_down_timer_down_cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reload,
  input  logic [WIDTH-1:0] reload_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (reload) begin
      count <= reload_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign is_one  = (count == WIDTH'(1));
  assign is_zero = (count == '0);

endmodule

// File: rtl/nbit_sync_down_timer.sv
// rtl/nbit_sync_down_timer.sv - loadable synchronous down timer with terminal-count pulse
// Holds the run/idle FSM, the reload register and the registered busy/tc flags.
module nbit_sync_down_timer
  import nbit_sync_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Count,
  output logic             busy,
  output logic             tc
);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             is_one;
  logic             is_zero;
  logic             run_step;
  logic             core_reload;
  logic             core_dec;

  // An enabled counting edge only happens when nothing of higher priority is asserted.
  always_comb begin
    run_step    = 1'b0;
    core_reload = 1'b0;
    core_dec    = 1'b0;
    if ((state == ST_RUN) && !load && !stop && en) begin
      run_step = 1'b1;
    end
    core_reload = run_step && is_one && auto_reload;
    core_dec    = run_step && !(is_one && auto_reload);
  end

  nbit_sync_down_timer_down_cnt_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (Clk),
    .clr       (!rst_n),
    .load      (load),
    .load_val  (load_val),
    .reload    (core_reload),
    .reload_val(reload_reg),
    .dec       (core_dec),
    .count     (Count),
    .is_one    (is_one),
    .is_zero   (is_zero)
  );

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      reload_reg <= '0;
      busy       <= 1'b0;
      tc         <= 1'b0;
    end else if (load) begin
      state      <= ST_IDLE;
      reload_reg <= load_val;
      busy       <= 1'b0;
      tc         <= 1'b0;
    end else if (stop) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!is_zero) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              tc <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (en && is_one) begin
            tc <= 1'b1;
            if (!auto_reload) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_sync_down_timer.sv
// tb/tb_nbit_sync_down_timer.sv - directed self-checking bench for the down timer
module tb_nbit_sync_down_timer;

  localparam int WIDTH = 4;

  logic             Clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] Count;
  logic             busy;
  logic             tc;

  int checks = 0;
  int errors = 0;

  nbit_sync_down_timer #(
    .WIDTH(WIDTH)
  ) dut (
    .Clk        (Clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .auto_reload(auto_reload),
    .Count      (Count),
    .busy       (busy),
    .tc         (tc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int exp_count, input bit exp_busy,
                           input bit exp_tc);
    check({tag, ".count"}, 32'(Count), 32'(exp_count));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; load_val = 4'd9;
    start = 1'b0; stop = 1'b0; en = 1'b0; auto_reload = 1'b0;

    // 1. reset beats load
    step(); step();
    check_all("reset", 0, 0, 0);
    rst_n = 1'b1; load = 1'b0;

    // 2. plain countdown from 5
    load = 1'b1; load_val = 4'd5; step();
    check_all("t2.load", 5, 0, 0);
    load = 1'b0; start = 1'b1; en = 1'b1; step();
    check_all("t2.start", 5, 1, 0);
    start = 1'b0;
    step(); check_all("t2.e1", 4, 1, 0);
    step(); check_all("t2.e2", 3, 1, 0);
    step(); check_all("t2.e3", 2, 1, 0);
    step(); check_all("t2.e4", 1, 1, 0);
    step(); check_all("t2.term", 0, 0, 1);
    step(); check_all("t2.after", 0, 0, 0);

    // 3. pause with en
    load = 1'b1; load_val = 4'd3; step();
    load = 1'b0; start = 1'b1; en = 1'b1; step();
    check_all("t3.start", 3, 1, 0);
    start = 1'b0;
    en = 1'b1; step(); check_all("t3.en1", 2, 1, 0);
    en = 1'b0; step(); check_all("t3.en0a", 2, 1, 0);
    en = 1'b0; step(); check_all("t3.en0b", 2, 1, 0);
    en = 1'b1; step(); check_all("t3.en1b", 1, 1, 0);
    en = 1'b1; step(); check_all("t3.term", 0, 0, 1);

    // 4. auto-reload of 2
    load = 1'b1; load_val = 4'd2; auto_reload = 1'b1; step();
    load = 1'b0; start = 1'b1; en = 1'b1; step();
    check_all("t4.start", 2, 1, 0);
    start = 1'b0;
    step(); check_all("t4.e1", 1, 1, 0);
    step(); check_all("t4.e2", 2, 1, 1);
    step(); check_all("t4.e3", 1, 1, 0);
    step(); check_all("t4.e4", 2, 1, 1);
    step(); check_all("t4.e5", 1, 1, 0);
    start = 1'b1;
    step(); check_all("t4.e6_start_ignored", 2, 1, 1);
    start = 1'b0; stop = 1'b1;
    step(); check_all("t4.stop", 2, 0, 0);
    stop = 1'b0; auto_reload = 1'b0;

    // 5a. zero-length timer
    load = 1'b1; load_val = 4'd0; step();
    load = 1'b0; start = 1'b1; step();
    check_all("t5.zero", 0, 0, 1);
    start = 1'b0; step();
    check_all("t5.zero_after", 0, 0, 0);

    // 5b. stop after three decrements from 15
    load = 1'b1; load_val = 4'd15; step();
    load = 1'b0; start = 1'b1; en = 1'b1; step();
    check_all("t5.start15", 15, 1, 0);
    start = 1'b0;
    step(); step(); step();
    check_all("t5.run12", 12, 1, 0);
    stop = 1'b1; step();
    check_all("t5.stop", 12, 0, 0);
    stop = 1'b0; step();
    check_all("t5.hold", 12, 0, 0);

    // 6a. load with coincident start aborts a run at 6
    load = 1'b1; load_val = 4'd8; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0; step(); step();
    check_all("t6.run6", 6, 1, 0);
    load = 1'b1; load_val = 4'd4; start = 1'b1; step();
    check_all("t6.load_wins", 4, 0, 0);
    load = 1'b0; start = 1'b0; step();
    check_all("t6.idle_hold", 4, 0, 0);

    // 6b. reset with coincident load and start at 6
    load = 1'b1; load_val = 4'd8; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0; step(); step();
    check_all("t6.run6b", 6, 1, 0);
    rst_n = 1'b0; load = 1'b1; load_val = 4'd4; start = 1'b1; step();
    check_all("t6.reset_wins", 0, 0, 0);
    rst_n = 1'b1; load = 1'b0; start = 1'b1; step();
    check_all("t6.zero_after_reset", 0, 0, 1);
    start = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
